qe_mac_sequencer: RTL and testbench

Time-multiplexed controller for the quadratic-equation / product-sum datapath. A single shared 16x8 unsigned multiplier and a 16-bit accumulator serve both modes:
- mode 0 evaluates a·x² + b·x + c by Horner's rule in two multiply steps.
- mode 1 accumulates Σ aᵢ·xᵢ over a burst of input beats.

The block replaces separate per-mode engines in the top level. It owns the input handshake, the result register and the done strobe.

---
 rtl/qe_mac_pkg.sv | 30 +++
 rtl/shared_mul.sv | 24 ++
 rtl/qe_mac_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_qe_mac_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qe_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qe_mac_pkg
//  Description : Shared types and constants for the quadratic-equation /
//                product-sum sequencer: state encoding, width defaults and
//                mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package qe_mac_pkg;

    // Default operand and accumulator widths; the accumulator is always
    // twice the operand width so a single 8x8 product fits without loss.
    localparam int DATA_W_DEF = 8;
    localparam int RES_W_DEF  = 16;

    // Operation selector, sampled on the first beat of an operation.
    localparam logic MODE_QE  = 1'b0;
    localparam logic MODE_MAC = 1'b1;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        QE1  = 3'd1,
        QE2  = 3'd2,
        MAC  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage : qe_mac_pkg
`default_nettype wire

// File: rtl/shared_mul.sv
`default_nettype none
// ============================================================================
//  Module      : shared_mul
//  Description : Combinational unsigned multiplier shared by both sequencer
//                modes. Full-width product; truncation and overflow
//                detection are left to the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_mul
    import qe_mac_pkg::*;
#(
    parameter int A_W = RES_W_DEF,
    parameter int B_W = DATA_W_DEF
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] product
);

    // Both operands zero-extended to the product width so nothing is lost.
    assign product = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};

endmodule : shared_mul
`default_nettype wire

// File: rtl/qe_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : qe_mac_sequencer
//  Description : Time-multiplexed controller around one shared multiplier and
//                one accumulator. Mode 0 evaluates a*x^2 + b*x + c by Horner's
//                rule in two multiply steps; mode 1 accumulates sum(a_i*x_i)
//                over a burst of beats terminated by last_input.
//  Revision    : 1.0 - initial release
// ============================================================================
module qe_mac_sequencer
    import qe_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF     // must be 2*DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_x,
    input  logic              mode,
    input  logic              valid_in,
    input  logic              last_input,
    output logic              ready_in,
    output logic              valid_out,
    output logic [RES_W-1:0]  result,
    output logic              overflow
);

    localparam int c_PROD_W = RES_W + DATA_W;
    localparam int c_PAD_W  = RES_W - DATA_W;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_c;
    logic [DATA_W-1:0]   r_x;
    logic [RES_W-1:0]    r_acc;
    logic                r_ovf_acc;
    logic [RES_W-1:0]    r_result;
    logic                r_overflow;
    logic                r_valid_out;

    logic [RES_W-1:0]    w_mul_a;
    logic [DATA_W-1:0]   w_mul_b;
    logic [RES_W-1:0]    w_addend;
    logic [c_PROD_W-1:0] w_prod;
    logic [RES_W-1:0]    w_prod_lo;
    logic                w_prod_ovf;
    logic [RES_W:0]      w_sum;
    logic                w_step_ovf;
    logic                w_accept;

    // Only IDLE and MAC take beats; everything else is busy.
    assign ready_in  = (r_state == IDLE) || (r_state == MAC);
    assign w_accept  = valid_in && ready_in;

    assign valid_out = r_valid_out;
    assign result    = r_result;
    assign overflow  = r_overflow;

    // Operand and addend selection for the shared multiplier/adder.
    // IDLE and MAC work on the live beat; the Horner steps use latched values.
    always_comb begin
        w_mul_a  = {{c_PAD_W{1'b0}}, in_a};
        w_mul_b  = in_x;
        w_addend = r_acc;
        case (r_state)
            QE1: begin
                w_mul_a  = {{c_PAD_W{1'b0}}, r_a};
                w_mul_b  = r_x;
                w_addend = {{c_PAD_W{1'b0}}, r_b};
            end
            QE2: begin
                w_mul_a  = r_acc;
                w_mul_b  = r_x;
                w_addend = {{c_PAD_W{1'b0}}, r_c};
            end
            default: begin
                w_mul_a  = {{c_PAD_W{1'b0}}, in_a};
                w_mul_b  = in_x;
                w_addend = r_acc;
            end
        endcase
    end

    shared_mul #(
        .A_W (RES_W),
        .B_W (DATA_W)
    ) u_shared_mul (
        .a       (w_mul_a),
        .b       (w_mul_b),
        .product (w_prod)
    );

    // Truncated product, plus the flags that feed the sticky overflow.
    assign w_prod_lo  = w_prod[RES_W-1:0];
    assign w_prod_ovf = |w_prod[c_PROD_W-1:RES_W];
    assign w_sum      = {1'b0, w_prod_lo} + {1'b0, w_addend};
    assign w_step_ovf = w_prod_ovf | w_sum[RES_W];

    // Sequencer FSM with registered result, overflow and done strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_x         <= '0;
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ovf_acc <= 1'b0;
                        if (mode == MODE_QE) begin
                            r_a     <= in_a;
                            r_b     <= in_b;
                            r_c     <= in_c;
                            r_x     <= in_x;
                            r_state <= QE1;
                        end else begin
                            // First product-sum beat seeds the accumulator.
                            r_acc     <= w_prod_lo;
                            r_ovf_acc <= w_prod_ovf;
                            if (last_input) begin
                                r_result    <= w_prod_lo;
                                r_overflow  <= w_prod_ovf;
                                r_valid_out <= 1'b1;
                                r_state     <= DONE;
                            end else begin
                                r_state <= MAC;
                            end
                        end
                    end
                end
                QE1: begin
                    r_acc     <= w_sum[RES_W-1:0];
                    r_ovf_acc <= r_ovf_acc | w_step_ovf;
                    r_state   <= QE2;
                end
                QE2: begin
                    r_acc       <= w_sum[RES_W-1:0];
                    r_ovf_acc   <= r_ovf_acc | w_step_ovf;
                    r_result    <= w_sum[RES_W-1:0];
                    r_overflow  <= r_ovf_acc | w_step_ovf;
                    r_valid_out <= 1'b1;
                    r_state     <= DONE;
                end
                MAC: begin
                    // The mode input is deliberately ignored inside a burst.
                    if (w_accept) begin
                        r_acc     <= w_sum[RES_W-1:0];
                        r_ovf_acc <= r_ovf_acc | w_step_ovf;
                        if (last_input) begin
                            r_result    <= w_sum[RES_W-1:0];
                            r_overflow  <= r_ovf_acc | w_step_ovf;
                            r_valid_out <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : qe_mac_sequencer
`default_nettype wire

// File: tb/tb_qe_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qe_mac_sequencer
//  Description : Self-checking bench for qe_mac_sequencer. A transaction-level
//                model predicts ready/valid/result/overflow every cycle;
//                directed scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qe_mac_sequencer;
    import qe_mac_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_a = '0, in_b = '0, in_c = '0, in_x = '0;
    logic        mode = 1'b0, valid_in = 1'b0, last_input = 1'b0;
    logic        ready_in, valid_out, overflow;
    logic [15:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    qe_mac_sequencer #(.DATA_W(8), .RES_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_x       (in_x),
        .mode       (mode),
        .valid_in   (valid_in),
        .last_input (last_input),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .result     (result),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks: cycles remaining with ready low, cycles until a pending
    // quadratic result appears, and the running burst sum.
    int  m_busy = 0;
    int  m_pend = 0;
    int  m_sum = 0;
    bit  m_ovf = 0;
    bit  m_burst = 0;
    int  m_pres = 0;
    bit  m_povf = 0;
    bit  m_ready = 1;
    bit  m_valid = 0;
    int  m_result = 0;
    bit  m_overflow = 0;
    bit  t_acc;
    int  t_p, t_s, t_t;
    bit  t_ov;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_busy = 0; m_pend = 0; m_sum = 0; m_ovf = 0; m_burst = 0;
            m_ready = 1; m_valid = 0; m_result = 0; m_overflow = 0;
        end else begin
            t_acc   = valid_in && m_ready;
            m_valid = 0;
            if (m_busy > 0) m_busy--;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_valid = 1; m_result = m_pres; m_overflow = m_povf;
                end
            end
            if (t_acc) begin
                if (!m_burst && mode == MODE_QE) begin
                    // (a*x + b)*x + c with each step reduced mod 2^16
                    t_p  = in_a * in_x;
                    t_s  = t_p + in_b;
                    t_ov = (t_p > 65535) || (t_s > 65535);
                    t_t  = t_s % 65536;
                    t_p  = t_t * in_x;
                    if (t_p > 65535) t_ov = 1;
                    t_s  = (t_p % 65536) + in_c;
                    if (t_s > 65535) t_ov = 1;
                    m_pres = t_s % 65536;
                    m_povf = t_ov;
                    m_pend = 2;
                    m_busy = 3;
                end else begin
                    t_p = in_a * in_x;
                    if (!m_burst) begin
                        m_sum = t_p; m_ovf = 0;
                    end else begin
                        t_s = m_sum + t_p;
                        if (t_s > 65535) m_ovf = 1;
                        m_sum = t_s % 65536;
                    end
                    m_burst = 1;
                    if (last_input) begin
                        m_burst = 0; m_valid = 1; m_result = m_sum;
                        m_overflow = m_ovf; m_busy = 1;
                    end
                end
            end
            m_ready = (m_busy == 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("ready_in",  ready_in,  m_ready);
        check("valid_out", valid_out, m_valid);
        check("result",    result,    m_result);
        check("overflow",  overflow,  m_overflow);
    end

    // ---------------- stimulus helpers ----------------
    task automatic offer(input logic [7:0] a, b, c, x, input logic md, lst);
        int g = 0;
        while (!ready_in && g < 20) begin
            @(posedge clk); #1; g++;
        end
        if (!ready_in) check("ready_timeout", 0, 1);
        in_a = a; in_b = b; in_c = c; in_x = x;
        mode = md; last_input = lst; valid_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        valid_in = 1'b0; last_input = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_lat,
                               input logic [15:0] exp_res, input logic exp_ovf);
        int lat = 1;
        while (!valid_out && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, result, exp_res);
        check({name, "_overflow"}, overflow, exp_ovf);
        @(posedge clk); #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_result", result, 16'h0000);
        check("reset_overflow", overflow, 1'b0);
        check("reset_valid", valid_out, 1'b0);
        check("reset_ready", ready_in, 1'b1);
        @(posedge clk); #1;

        // Quadratic: 2*25 + 3*5 + 4 = 69
        offer(8'd2, 8'd3, 8'd4, 8'd5, MODE_QE, 1'b0);
        idle_in();
        check("qe_ready_busy", ready_in, 1'b0);
        wait_result("qe_basic", 3, 16'd69, 1'b0);

        // Product-sum: 2 + 12 + 30 = 44
        offer(8'd1, 8'd0, 8'd0, 8'd2, MODE_MAC, 1'b0);
        offer(8'd3, 8'd0, 8'd0, 8'd4, MODE_MAC, 1'b0);
        offer(8'd5, 8'd0, 8'd0, 8'd6, MODE_MAC, 1'b1);
        idle_in();
        wait_result("mac_basic", 1, 16'd44, 1'b0);

        // Quadratic overflow: acc=0xFF00 then 0xFF00*0xFF+0xFF -> 0x01FF
        offer(8'hFF, 8'hFF, 8'hFF, 8'hFF, MODE_QE, 1'b0);
        idle_in();
        wait_result("qe_ovf", 3, 16'h01FF, 1'b1);

        // Product-sum overflow: 2*0xFE01 -> 0xFC02 with carry
        offer(8'hFF, 8'd0, 8'd0, 8'hFF, MODE_MAC, 1'b0);
        offer(8'hFF, 8'd0, 8'd0, 8'hFF, MODE_MAC, 1'b1);
        idle_in();
        wait_result("mac_ovf", 1, 16'hFC02, 1'b1);

        // Sticky flag clears on the next operation
        offer(8'd0, 8'd0, 8'd7, 8'd1, MODE_QE, 1'b0);
        idle_in();
        wait_result("ovf_clear", 3, 16'd7, 1'b0);

        // Beats offered while busy are dropped
        offer(8'd2, 8'd3, 8'd4, 8'd5, MODE_QE, 1'b0);
        in_a = 8'd99; in_x = 8'd99; mode = MODE_MAC; last_input = 1'b1;
        valid_in = 1'b1;
        wait_result("qe_dropped", 3, 16'd69, 1'b0);
        idle_in();
        @(posedge clk); #1;
        check("dropped_no_strobe", valid_out, 1'b0);

        // Mode toggling mid-burst, with an idle gap inside MAC
        offer(8'd1, 8'd0, 8'd0, 8'd2, MODE_MAC, 1'b0);
        idle_in();
        @(posedge clk); #1;
        check("mac_gap_ready", ready_in, 1'b1);
        offer(8'd3, 8'd0, 8'd0, 8'd4, MODE_QE, 1'b0);
        offer(8'd5, 8'd0, 8'd0, 8'd6, MODE_QE, 1'b1);
        idle_in();
        wait_result("mac_mode_toggle", 1, 16'd44, 1'b0);

        // Reset in the middle of a burst
        offer(8'd10, 8'd0, 8'd0, 8'd10, MODE_MAC, 1'b0);
        offer(8'd20, 8'd0, 8'd0, 8'd20, MODE_MAC, 1'b0);
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst2_result", result, 16'h0000);
        check("rst2_overflow", overflow, 1'b0);
        check("rst2_valid", valid_out, 1'b0);
        check("rst2_ready", ready_in, 1'b1);
        offer(8'd7, 8'd0, 8'd0, 8'd8, MODE_MAC, 1'b1);
        idle_in();
        wait_result("after_reset", 1, 16'd56, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule : tb_qe_mac_sequencer
`default_nettype wire
